seq_divider: RTL and testbench



---
 rtl/div_pkg.sv | 16 +
 rtl/seq_divider_if.sv | 26 ++
 rtl/div_step.sv | 35 +++
 rtl/seq_divider.sv | 175 +++++++++++++++++
 tb/tb_seq_divider.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encodings, default width
// and the quotient reported on division by zero.
package div_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Wide all-ones constant; users slice off the low WIDTH bits.
  localparam logic [63:0] DIV0_QUOTIENT = {64{1'b1}};

endpackage : div_pkg

// File: rtl/seq_divider_if.sv
// Launch/result bundle between the control path (master) and the divider (slave).
interface seq_divider_if #(
  parameter int WIDTH = div_pkg::DEF_WIDTH
);

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface : seq_divider_if

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor if the shifted partial remainder is large enough.
module div_step #(
  parameter int WIDTH = div_pkg::DEF_WIDTH
) (
  input  logic [WIDTH:0]   p_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   p_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] dvs_ext_s;
  logic           ge_s;

  assign shifted_s = {p_in[WIDTH-1:0], bit_in};
  assign dvs_ext_s = {1'b0, divisor};
  // A set top bit means the shift overflowed, which is always >= divisor.
  assign ge_s      = p_in[WIDTH] | (shifted_s >= dvs_ext_s);

  // Compare/subtract/restore decision.
  always_comb begin
    p_out = shifted_s;
    q_bit = 1'b0;
    if (ge_s) begin
      p_out = shifted_s - dvs_ext_s;
      q_bit = 1'b1;
    end else begin
      p_out = shifted_s;
      q_bit = 1'b0;
    end
  end

endmodule : div_step

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, unsigned or signed
// (truncating toward zero). Results and flags are registered and held.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  state_e           state_r, state_nxt_s;
  logic [WIDTH-1:0] dvd_r, dvd_nxt_s;
  logic [WIDTH-1:0] dvs_r, dvs_nxt_s;
  logic [WIDTH-1:0] q_r, q_nxt_s;
  logic [WIDTH:0]   p_r, p_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             q_neg_r, q_neg_nxt_s;
  logic             r_neg_r, r_neg_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic             div0_r, div0_nxt_s;
  logic [WIDTH-1:0] quo_r, quo_nxt_s;
  logic [WIDTH-1:0] rem_r, rem_nxt_s;

  logic             a_neg_s, b_neg_s, div_zero_s, last_iter_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH:0]   step_p_s;
  logic             step_q_s;

  // Magnitudes are WIDTH bits wide, so the most-negative value maps to itself.
  assign a_neg_s     = bus.signed_op & bus.dividend[WIDTH-1];
  assign b_neg_s     = bus.signed_op & bus.divisor[WIDTH-1];
  assign a_mag_s     = a_neg_s ? -bus.dividend : bus.dividend;
  assign b_mag_s     = b_neg_s ? -bus.divisor  : bus.divisor;
  assign div_zero_s  = (bus.divisor == {WIDTH{1'b0}});
  assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_in    (p_r),
    .bit_in  (dvd_r[WIDTH-1]),
    .divisor (dvs_r),
    .p_out   (step_p_s),
    .q_bit   (step_q_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start && !div_zero_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_iter_s) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FIX:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath and output next values; everything holds unless the state acts.
  always_comb begin
    dvd_nxt_s   = dvd_r;
    dvs_nxt_s   = dvs_r;
    q_nxt_s     = q_r;
    p_nxt_s     = p_r;
    cnt_nxt_s   = cnt_r;
    q_neg_nxt_s = q_neg_r;
    r_neg_nxt_s = r_neg_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    div0_nxt_s  = div0_r;
    quo_nxt_s   = quo_r;
    rem_nxt_s   = rem_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (div_zero_s) begin
            quo_nxt_s  = DIV0_QUOTIENT[WIDTH-1:0];
            rem_nxt_s  = bus.dividend;
            div0_nxt_s = 1'b1;
            done_nxt_s = 1'b1;
            busy_nxt_s = 1'b0;
          end else begin
            dvd_nxt_s   = a_mag_s;
            dvs_nxt_s   = b_mag_s;
            q_neg_nxt_s = a_neg_s ^ b_neg_s;
            r_neg_nxt_s = a_neg_s;
            p_nxt_s     = {(WIDTH+1){1'b0}};
            q_nxt_s     = {WIDTH{1'b0}};
            cnt_nxt_s   = {CNT_W{1'b0}};
            busy_nxt_s  = 1'b1;
          end
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      RUN: begin
        p_nxt_s    = step_p_s;
        q_nxt_s    = {q_r[WIDTH-2:0], step_q_s};
        dvd_nxt_s  = {dvd_r[WIDTH-2:0], 1'b0};
        cnt_nxt_s  = cnt_r + CNT_W'(1);
        busy_nxt_s = 1'b1;
      end
      FIX: begin
        quo_nxt_s  = q_neg_r ? -q_r : q_r;
        rem_nxt_s  = r_neg_r ? -p_r[WIDTH-1:0] : p_r[WIDTH-1:0];
        div0_nxt_s = 1'b0;
        done_nxt_s = 1'b1;
        busy_nxt_s = 1'b0;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_r   <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      p_r     <= {(WIDTH+1){1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      div0_r  <= 1'b0;
      quo_r   <= {WIDTH{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
    end else begin
      dvd_r   <= dvd_nxt_s;
      dvs_r   <= dvs_nxt_s;
      q_r     <= q_nxt_s;
      p_r     <= p_nxt_s;
      cnt_r   <= cnt_nxt_s;
      q_neg_r <= q_neg_nxt_s;
      r_neg_r <= r_neg_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      div0_r  <= div0_nxt_s;
      quo_r   <= quo_nxt_s;
      rem_r   <= rem_nxt_s;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = div0_r;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, hand-written multi-cycle
// sequences and randomized operations against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        s;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; SV int division truncates toward zero.
  task automatic model(input logic s, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output logic dz);
    int sa, sb, qi, ri;
    if (b == 16'd0) begin
      q  = 16'hFFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      sa = s ? int'($signed(a)) : int'(a);
      sb = s ? int'($signed(b)) : int'(b);
      qi = sa / sb;
      ri = sa % sb;
      q  = qi[15:0];
      r  = ri[15:0];
      dz = 1'b0;
    end
  endtask

  // Call at a negedge; returns #1 after the launch edge with start dropped.
  task automatic launch(input logic s, input logic [15:0] a, input logic [15:0] b);
    bus.start     = 1'b1;
    bus.signed_op = s;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts negedges after the launch edge until done (bounded).
  task automatic wait_done(input int n0, output int n, output int busy_n);
    n      = n0;
    busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.busy) busy_n++;
    end while (!bus.done && n < 100);
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  vec_t        tbl[$];
  logic [15:0] eq, er;
  logic        edz;
  int          n, bn, pulses;

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = 16'd0;
    bus.divisor   = 16'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_q", {16'd0, bus.quotient}, 32'd0);
    chk("reset_r", {16'd0, bus.remainder}, 32'd0);
    chk("reset_dz", {31'd0, bus.div_by_zero}, 32'd0);
    rst = 1'b0;

    tbl.push_back('{1'b0, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0});
    tbl.push_back('{1'b1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0});
    tbl.push_back('{1'b1, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0});
    tbl.push_back('{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0});
    tbl.push_back('{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0});
    tbl.push_back('{1'b0, 16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1'b1});
    tbl.push_back('{1'b1, 16'hFB2E, 16'h0000, 16'hFFFF, 16'hFB2E, 1'b1});
    tbl.push_back('{1'b1, 16'hFFFF, 16'h0002, 16'h0000, 16'hFFFF, 1'b0});
    tbl.push_back('{1'b1, 16'h8000, 16'h0002, 16'hC000, 16'h0000, 1'b0});
    tbl.push_back('{1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0});
    tbl.push_back('{1'b0, 16'h00C8, 16'h000A, 16'h0014, 16'h0000, 1'b0});
    tbl.push_back('{1'b1, 16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0});

    @(negedge clk);
    foreach (tbl[i]) begin
      launch(tbl[i].s, tbl[i].a, tbl[i].b);
      wait_done(0, n, bn);
      chk("tbl_q", {16'd0, bus.quotient}, {16'd0, tbl[i].q});
      chk("tbl_r", {16'd0, bus.remainder}, {16'd0, tbl[i].r});
      chk("tbl_dz", {31'd0, bus.div_by_zero}, {31'd0, tbl[i].dz});
      chk("tbl_latency", n, tbl[i].dz ? 32'd1 : 32'd18);
      chk("tbl_busy_cycles", bn, tbl[i].dz ? 32'd0 : 32'd17);
      @(negedge clk);
      chk("tbl_done_single", {31'd0, bus.done}, 32'd0);
      chk("tbl_q_hold", {16'd0, bus.quotient}, {16'd0, tbl[i].q});
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    launch(1'b0, 16'd1000, 16'd3);
    n = 0;
    repeat (3) begin @(negedge clk); n++; end
    bus.dividend = 16'd5;
    bus.divisor  = 16'd5;
    bus.start    = 1'b1;
    @(negedge clk);
    n++;
    bus.start = 1'b0;
    wait_done(n, n, bn);
    chk("busy_ignore_q", {16'd0, bus.quotient}, 32'h014D);
    chk("busy_ignore_r", {16'd0, bus.remainder}, 32'h0001);
    chk("busy_ignore_latency", n, 32'd18);
    launch(1'b0, 16'd9, 16'd2);
    wait_done(0, n, bn);
    chk("b2b_q", {16'd0, bus.quotient}, 32'h0004);
    chk("b2b_r", {16'd0, bus.remainder}, 32'h0001);
    chk("b2b_latency", n, 32'd18);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    launch(1'b0, 16'd1000, 16'd3);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_q", {16'd0, bus.quotient}, 32'd0);
    chk("midrst_r", {16'd0, bus.remainder}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done || bus.busy) pulses++;
    end
    chk("midrst_no_activity", pulses, 32'd0);
    launch(1'b0, 16'd200, 16'd10);
    wait_done(0, n, bn);
    chk("after_rst_q", {16'd0, bus.quotient}, 32'h0014);
    chk("after_rst_r", {16'd0, bus.remainder}, 32'h0000);

    // Back-to-back divide-by-zero launches give consecutive done pulses.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.signed_op = 1'b0;
    bus.dividend  = 16'h1111;
    bus.divisor   = 16'h0000;
    @(negedge clk);
    chk("div0_b2b_done1", {31'd0, bus.done}, 32'd1);
    chk("div0_b2b_r1", {16'd0, bus.remainder}, 32'h1111);
    bus.dividend = 16'h2222;
    @(negedge clk);
    bus.start = 1'b0;
    chk("div0_b2b_done2", {31'd0, bus.done}, 32'd1);
    chk("div0_b2b_r2", {16'd0, bus.remainder}, 32'h2222);
    chk("div0_b2b_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    chk("div0_b2b_done3", {31'd0, bus.done}, 32'd0);

    // Randomized operations against the reference model.
    for (int k = 0; k < 150; k++) begin
      logic        s;
      logic [15:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 16'h0000;
        1:       b = 16'hFFFF;
        2:       a = 16'h8000;
        3:       b = 16'($urandom_range(1, 7));
        default: b = b;
      endcase
      model(s, a, b, eq, er, edz);
      launch(s, a, b);
      wait_done(0, n, bn);
      chk("rand_q", {16'd0, bus.quotient}, {16'd0, eq});
      chk("rand_r", {16'd0, bus.remainder}, {16'd0, er});
      chk("rand_dz", {31'd0, bus.div_by_zero}, {31'd0, edz});
      chk("rand_latency", n, edz ? 32'd1 : 32'd18);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq_divider
